// File: rtl/nibble_serial_alu_if.sv
// nibble_serial_alu_if: command/operand/result bus of the nibble-serial ALU
interface nibble_serial_alu_if #(parameter int W = 32);
  logic         start;
  logic [2:0]   cmd;
  logic [W-1:0] word1;
  logic [W-1:0] word2;
  logic         busy;
  logic         is_latest;
  logic         done;
  logic         carry;
  logic [W-1:0] result;
  modport master(output start, cmd, word1, word2, input busy, is_latest, done, carry, result);
  modport slave(input start, cmd, word1, word2, output busy, is_latest, done, carry, result);
endinterface

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: 32-bit add/sub/logic/shift unit using one 4-bit slice, one nibble per clock
module nibble_serial_alu #(parameter int CNT_SIZE = 3) (
  input logic clk,
  input logic reset,
  nibble_serial_alu_if.slave bus
);
  localparam int W = 4 << CNT_SIZE;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, XOR = 3'd4, RSH = 3'd5, LSH = 3'd6;
  localparam logic [CNT_SIZE-1:0] ZERO = '0, ONE = 1, LAST = '1, PEN = LAST - ONE;
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state;
  logic [2:0]          op;
  logic [W-1:0]        a, b;
  logic [CNT_SIZE-1:0] idx;
  logic                cin;
  logic [3:0]          d1, d2, s;
  logic [4:0]          sum;
  logic                cout, rev, last, arith;
  always_comb begin
    d1 = a[{idx, 2'b00} +: 4];
    d2 = b[{idx, 2'b00} +: 4];
    arith = op == ADD || op == SUB;
    sum = {1'b0, d1} + {1'b0, op == SUB ? ~d2 : d2} + {4'b0, cin};
    s = arith ? sum[3:0] : op == AND ? d1 & d2 : op == OR ? d1 | d2 : op == XOR ? d1 ^ d2 :
        op == RSH ? {cin, d2[3:1]} : op == LSH ? {d2[2:0], cin} : 4'h0;
    cout = arith ? sum[4] : op == RSH ? d2[0] : op == LSH ? d2[3] : 1'b0;
    rev = op == RSH;
    last = idx == (rev ? ZERO : LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      a <= '0;
      b <= '0;
      idx <= '0;
      cin <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.is_latest <= 1'b0;
      bus.carry <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state <= RUN;
          op <= bus.cmd;
          a <= bus.word1;
          b <= bus.word2;
          bus.result <= '0;
          cin <= bus.cmd == SUB;
          idx <= bus.cmd == RSH ? LAST : ZERO;
          bus.busy <= 1'b1;
          bus.is_latest <= 1'b0;
        end
      end else begin
        bus.result[{idx, 2'b00} +: 4] <= s;
        cin <= cout;
        if (last) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.is_latest <= 1'b0;
          bus.carry <= arith & cout;
          idx <= '0;
        end else begin
          idx <= rev ? idx - ONE : idx + ONE;
          bus.is_latest <= idx == (rev ? ONE : PEN);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb_nibble_serial_alu: randomized and directed checks of the nibble-serial ALU against a word-level model
module tb_nibble_serial_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  nibble_serial_alu_if #(.W(32)) bus();
  nibble_serial_alu #(.CNT_SIZE(3)) dut(.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [2:0]  tc[10] = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd5, 3'd1, 3'd6, 3'd1, 3'd2, 3'd4};
  logic [31:0] ta[10] = '{32'hEFFFFFFF, 32'hFFFF0FFF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678,
                          32'h00000000, 32'hCAFEF00D, 32'h00000005, 32'hF0F0AAAA, 32'hFFFF0000};
  logic [31:0] tb_[10] = '{32'h00000001, 32'h00000002, 32'h00000001, 32'h06000000, 32'h00000011,
                           32'h00000001, 32'h80000001, 32'h00000003, 32'h0FF0FF00, 32'h0F0F0F0F};
  logic [31:0] tr[10] = '{32'hF0000000, 32'hFFFF1001, 32'h00000000, 32'h03000000, 32'h00000008,
                          32'hFFFFFFFF, 32'h00000002, 32'h00000002, 32'h00F0AA00, 32'hF0F00F0F};
  logic        ty[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'd0: return {1'b0, x} + {1'b0, y};
      3'd1: return {x >= y, x - y};
      3'd2: return {1'b0, x & y};
      3'd3: return {1'b0, x | y};
      3'd4: return {1'b0, x ^ y};
      3'd5: return {1'b0, y >> 1};
      3'd6: return {1'b0, y << 1};
      default: return 33'd0;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y, input bit b2b,
                       output int lat, output logic [31:0] lm, output logic [31:0] res, output logic cy);
    if (!b2b) @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = c;
    bus.word1 = x;
    bus.word2 = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    lm = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.is_latest) lm[k] = 1'b1;
      if (bus.done) lat = k;
    end
    res = bus.result;
    cy = bus.carry;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.is_latest !== 1'b0) begin bad++; $display("FAIL reset_latest got=%b exp=0", bus.is_latest); end
    if (bus.carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", bus.carry); end
    if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int lat;
    logic [31:0] lm, res;
    logic cy;
    for (int i = 0; i < 10; i++) begin
      do_op(tc[i], ta[i], tb_[i], 1'b0, lat, lm, res, cy);
      total += 5;
      if (lat != 8) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=8", i, lat); end
      if (lm !== 32'h80) begin bad++; $display("FAIL dir%0d_is_latest got=%h exp=00000080", i, lm); end
      if (res !== tr[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, tr[i]); end
      if (cy !== ty[i]) begin bad++; $display("FAIL dir%0d_carry got=%b exp=%b", i, cy, ty[i]); end
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bus.busy); end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", bus.done); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] lm, res, x, y;
    logic [32:0] e;
    logic cy;
    logic [2:0] c;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      x = $urandom;
      y = i % 5 == 0 ? x : $urandom;
      e = model(c, x, y);
      do_op(c, x, y, 1'b0, lat, lm, res, cy);
      total += 3;
      if (lat != 8) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=8", i, lat); end
      if (res !== e[31:0]) begin bad++; $display("FAIL rnd%0d_result cmd=%0d got=%h exp=%h", i, c, res, e[31:0]); end
      if (cy !== e[32]) begin bad++; $display("FAIL rnd%0d_carry cmd=%0d got=%b exp=%b", i, c, cy, e[32]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] lm, res, x, y;
    logic [32:0] e;
    logic cy;
    logic [2:0] c;
    for (int i = 0; i < 4; i++) begin
      c = 3'($urandom_range(0, 6));
      x = $urandom;
      y = $urandom;
      e = model(c, x, y);
      do_op(c, x, y, i != 0, lat, lm, res, cy);
      total += 3;
      if (lat != 8) begin bad++; $display("FAIL b2b%0d_latency got=%0d exp=8", i, lat); end
      if (res !== e[31:0]) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", i, res, e[31:0]); end
      if (cy !== e[32]) begin bad++; $display("FAIL b2b%0d_carry got=%b exp=%b", i, cy, e[32]); end
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 3'd0;
    bus.word1 = 32'h12345678;
    bus.word2 = 32'h11111111;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) lat = k;
      if (k == 2) begin
        bus.start = 1'b1;
        bus.cmd = 3'd4;
        bus.word1 = $urandom;
        bus.word2 = $urandom;
      end
      if (k == 3) bus.start = 1'b0;
    end
    total += 2;
    if (lat != 8) begin bad++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
    if (bus.result !== 32'h23456789) begin bad++; $display("FAIL ignore_result got=%h exp=23456789", bus.result); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] lm, res, x, y;
    logic [32:0] e;
    logic cy;
    bit seen = 0;
    do_op(3'd0, 32'hFFFFFFFF, 32'h1, 1'b0, lat, lm, res, cy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 3'd0;
    bus.word1 = 32'h0F0F0F0F;
    bus.word2 = 32'h01010101;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    total += 5;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", bus.done); end
    if (bus.is_latest !== 1'b0) begin bad++; $display("FAIL mid_latest got=%b exp=0", bus.is_latest); end
    if (bus.carry !== 1'b0) begin bad++; $display("FAIL mid_carry got=%b exp=0", bus.carry); end
    if (bus.result !== 32'h0) begin bad++; $display("FAIL mid_result got=%h exp=0", bus.result); end
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (bus.done) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL mid_no_done got=1 exp=0"); end
    x = $urandom;
    y = $urandom;
    e = model(3'd0, x, y);
    do_op(3'd0, x, y, 1'b0, lat, lm, res, cy);
    total += 3;
    if (lat != 8) begin bad++; $display("FAIL post_reset_latency got=%0d exp=8", lat); end
    if (res !== e[31:0]) begin bad++; $display("FAIL post_reset_result got=%h exp=%h", res, e[31:0]); end
    if (cy !== e[32]) begin bad++; $display("FAIL post_reset_carry got=%b exp=%b", cy, e[32]); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cmd = '0;
    bus.word1 = '0;
    bus.word2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
